burst_master: RTL and testbench

BURST_MASTER -- requirements
Module: burst_master

---
 rtl/burst_master.sv | 128 ++++++++++++
 tb/tb_burst_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/burst_master.sv
// burst_master: fixed-length read/write burst master over a valid/ready bus.
// Optional stall watchdog enabled by defining BURST_MASTER_TIMEOUT_EN.
module burst_master #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W*BURST_LEN-1:0] wr_buf_data,
  output logic [DATA_W*BURST_LEN-1:0] rd_buf_data,
  output logic                        done,
  output logic                        err,
  output logic                        ar_valid,
  input  logic                        ar_ready,
  output logic [ADDR_W-1:0]           ar_addr,
  input  logic                        r_valid,
  output logic                        r_ready,
  input  logic [DATA_W-1:0]           r_data,
  output logic                        aw_valid,
  input  logic                        aw_ready,
  output logic [ADDR_W-1:0]           aw_addr,
  output logic                        w_valid,
  input  logic                        w_ready,
  output logic [DATA_W-1:0]           w_data,
  input  logic                        b_valid,
  output logic                        b_ready
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int BUF_W = DATA_W * BURST_LEN;
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BUF_W-1:0] wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic last, ar_hs, r_hs, aw_hs, w_hs, b_hs, tmo;
  assign last  = beat_q == BW'(BURST_LEN - 1);
  assign ar_hs = ar_valid && ar_ready;
  assign r_hs  = r_ready && r_valid;
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  assign b_hs  = b_ready && b_valid;
  assign cmd_ready = state_q == IDLE;
  assign ar_valid  = state_q == AR;
  assign r_ready   = state_q == R;
  assign aw_valid  = state_q == AW;
  assign w_valid   = state_q == W;
  assign b_ready   = state_q == B;
  assign done      = state_q == DONE;
  assign ar_addr   = ar_valid ? addr_q : '0;
  assign aw_addr   = aw_valid ? addr_q : '0;
  assign w_data    = w_valid ? wbuf_q[beat_q*DATA_W +: DATA_W] : '0;
  assign rd_buf_data = rbuf_q;
`ifdef BURST_MASTER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic err_q, busy, any_hs;
  assign busy   = !(state_q inside {IDLE, DONE});
  assign any_hs = ar_hs || r_hs || aw_hs || w_hs || b_hs;
  // the TIMEOUT-th consecutive idle bus cycle aborts the burst at its closing edge
  assign tmo     = busy && !any_hs && stall_q == SW'(TIMEOUT - 1);
  assign stall_d = (!busy || any_hs || tmo) ? '0 : stall_q + SW'(1);
  assign err     = err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        wbuf_d  = wr_buf_data;
        state_d = cmd_write ? AW : AR;
      end
      AR: state_d = ar_hs ? R : AR;
      R: if (r_hs) begin
        rbuf_d[beat_q*DATA_W +: DATA_W] = r_data;
        beat_d  = last ? '0 : beat_q + BW'(1);
        state_d = last ? DONE : R;
      end
      AW: state_d = aw_hs ? W : AW;
      W: if (w_hs) begin
        beat_d  = last ? '0 : beat_q + BW'(1);
        state_d = last ? B : W;
      end
      B: state_d = b_hs ? DONE : B;
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      beat_d  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
    end
  end
endmodule

// File: tb/tb_burst_master.sv
// tb_burst_master: directed bench for burst_master with hand-computed expectations.
module tb_burst_master;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [2:0] cmd_addr = '0, ar_addr, aw_addr;
  logic [31:0] wr_buf_data = '0, rd_buf_data;
  logic done, err, ar_valid, ar_ready = 1'b0, r_valid = 1'b0, r_ready;
  logic [3:0] r_data = '0, w_data;
  logic aw_valid, aw_ready = 1'b0, w_valid, w_ready = 1'b0, b_valid = 1'b0, b_ready;
  int checks = 0, errors = 0;
  burst_master #(.ADDR_W(3), .DATA_W(4), .BURST_LEN(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .wr_buf_data(wr_buf_data),
    .rd_buf_data(rd_buf_data), .done(done), .err(err), .ar_valid(ar_valid),
    .ar_ready(ar_ready), .ar_addr(ar_addr), .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .b_valid(b_valid),
    .b_ready(b_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] wbuf;
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_ar_valid", 32'(ar_valid), 0);
    check("rst_rd_buf", rd_buf_data, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_w_data", 32'(w_data), 0);
    rst_n = 1'b1;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    // write burst, addr 2, every ready/valid held high
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd2; wr_buf_data = 32'h76543210;
    aw_ready = 1; w_ready = 1; b_valid = 1;
    step();
    cmd_valid = 0;
    check("wr_aw_valid", 32'(aw_valid), 1);
    check("wr_aw_addr", 32'(aw_addr), 2);
    check("wr_cmd_ready", 32'(cmd_ready), 0);
    step();
    for (int k = 0; k < 8; k++) begin
      check("wr_w_valid", 32'(w_valid), 1);
      check("wr_w_data", 32'(w_data), k);
      check("wr_one_hot", 32'(ar_valid + aw_valid), 0);
      step();
    end
    check("wr_b_ready", {w_valid, b_ready}, 1);
    step();
    check("wr_done", 32'(done), 1);
    step();
    check("wr_done_pulse", {done, cmd_ready}, 1);
    check("wr_rbuf_kept", rd_buf_data, 0);
    aw_ready = 0; w_ready = 0; b_valid = 0;
    // read burst, addr 5, r_data = 8 + beat
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd5; ar_ready = 1; r_valid = 1;
    step();
    cmd_valid = 0;
    check("rd_ar_valid", 32'(ar_valid), 1);
    check("rd_ar_addr", 32'(ar_addr), 5);
    step();
    for (int k = 0; k < 8; k++) begin
      check("rd_r_ready", 32'(r_ready), 1);
      r_data = 4'(8 + k);
      step();
    end
    check("rd_done", {done, cmd_ready}, 2);
    check("rd_buf", rd_buf_data, 32'hFEDCBA98);
    step();
    check("rd_idle", {done, cmd_ready}, 1);
    ar_ready = 0; r_valid = 0;
    // write with w_ready stalling every other cycle
    wbuf = 32'h9ABCDEF0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd6; wr_buf_data = wbuf; aw_ready = 1; b_valid = 1;
    step();
    cmd_valid = 0;
    wr_buf_data = '0;
    step();
    for (int c = 0; c < 16; c++) begin
      w_ready = c[0];
      check("st_w_valid", 32'(w_valid), 1);
      check("st_w_data", 32'(w_data), 32'(wbuf[(c/2)*4 +: 4]));
      step();
    end
    check("st_b_ready", {w_valid, b_ready}, 1);
    step();
    check("st_done", 32'(done), 1);
    step();
    aw_ready = 0; w_ready = 0; b_valid = 0;
    // reset in the middle of a read after beat 3
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd1; ar_ready = 1; r_valid = 1;
    step();
    cmd_valid = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      r_data = 4'(1 + k);
      step();
    end
    check("ab_partial", rd_buf_data, 32'hFEDC4321);
    rst_n = 0;
    step();
    check("ab_bus", {ar_valid, r_ready, aw_valid, w_valid, b_ready}, 0);
    check("ab_rbuf", rd_buf_data, 0);
    check("ab_done_err", {done, err}, 0);
    rst_n = 1; ar_ready = 0; r_valid = 0;
    step();
    check("ab_cmd_ready", {done, cmd_ready}, 1);
    // ar_ready stuck low
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd3;
    step();
    cmd_valid = 0;
    for (int c = 0; c < 16; c++) begin
      check("to_ar_valid", {ar_valid, err}, 2);
      step();
    end
`ifdef BURST_MASTER_TIMEOUT_EN
    check("to_err", {err, ar_valid, done, cmd_ready}, 4'b1001);
    step();
    check("to_err_pulse", 32'(err), 0);
`else
    check("to_wait", {err, ar_valid, done}, 3'b010);
    step();
    check("to_still", {err, ar_valid}, 1);
`endif
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    // cmd_valid held through a read burst
    cmd_valid = 1; cmd_write = 0; cmd_addr = 3'd4; ar_ready = 1; r_valid = 1;
    step();
    check("hold_busy", {ar_valid, cmd_ready}, 2);
    for (int k = 0; k < 9; k++) step();
    check("hold_done", {done, cmd_ready, ar_valid}, 3'b100);
    step();
    check("hold_idle", {cmd_ready, ar_valid}, 2);
    step();
    cmd_valid = 0;
    check("hold_second", {cmd_ready, ar_valid, 3'(ar_addr)}, 5'b01100);
    for (int k = 0; k < 9; k++) step();
    check("hold_done2", 32'(done), 1);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
